// File: rtl/cordic_seq_ctrl_if.sv
// Control bundle between the CORDIC top-level handshake and its sequencer.
interface cordic_seq_ctrl_if #(
  parameter int IW = 5
);
  logic          start;
  logic          abort;
  logic          ready;
  logic          busy;
  logic          load;
  logic          iter_en;
  logic [IW-1:0] iter;
  logic          last;
  logic          done;

  modport master (
    output start, abort,
    input  ready, busy, load, iter_en, iter, last, done
  );

  modport slave (
    input  start, abort,
    output ready, busy, load, iter_en, iter, last, done
  );
endinterface

// File: rtl/cordic_seq_ctrl.sv
// CORDIC sequencer: load pulse, N_ITER enabled iterations, done pulse; start-to-done N_ITER+2 cycles.
// No backpressure: start is taken only while ready=1 and is dropped (not queued) otherwise.
module cordic_seq_ctrl #(
  parameter int N_ITER = 32,
  parameter int IW     = 5
) (
  input logic              clock,
  input logic              reset,
  cordic_seq_ctrl_if.slave ctrl
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_ITER - 1);

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] iter_q;
  logic [IW-1:0] iter_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      iter_q <= '0;
    end else begin
      state  <= state_nxt;
      iter_q <= iter_nxt;
    end
  end

  // abort only matters while an operation is in flight (LOAD/ITER)
  always_comb begin
    state_nxt = state;
    iter_nxt  = iter_q;
    case (state)
      IDLE: begin
        if (ctrl.start) state_nxt = LOAD;
      end
      LOAD: begin
        iter_nxt  = '0;
        state_nxt = ctrl.abort ? IDLE : ITER;
      end
      ITER: begin
        if (ctrl.abort) begin
          state_nxt = IDLE;
          iter_nxt  = '0;
        end else if (iter_q == LAST_IDX) begin
          state_nxt = DONE;
          iter_nxt  = '0;
        end else begin
          iter_nxt = iter_q + IW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        iter_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    ctrl.ready   = (state == IDLE);
    ctrl.busy    = (state == LOAD) || (state == ITER);
    ctrl.load    = (state == LOAD);
    ctrl.iter_en = (state == ITER);
    ctrl.iter    = iter_q;
    ctrl.last    = (state == ITER) && (iter_q == LAST_IDX);
    ctrl.done    = (state == DONE);
  end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Bench for cordic_seq_ctrl: default N_ITER=32 instance plus an N_ITER=1 corner instance.
module tb_cordic_seq_ctrl;
  localparam int N  = 32;
  localparam int IW = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cordic_seq_ctrl_if #(.IW(IW)) bus ();
  cordic_seq_ctrl_if #(.IW(1))  bus1 ();

  cordic_seq_ctrl #(.N_ITER(N), .IW(IW)) dut (.clock(clock), .reset(reset), .ctrl(bus));
  cordic_seq_ctrl #(.N_ITER(1), .IW(1))  dut1 (.clock(clock), .reset(reset), .ctrl(bus1));

  // Stand-in angle accumulator: cleared by load, otherwise accumulates during iter_en.
  logic [31:0] z = 32'h1234_5678;
  always @(posedge clock) begin
    if (bus.load) z <= '0;
    else if (bus.iter_en) z <= z + 32'(bus.iter) + 32'd1;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_iter = 0;
  int n_iter_en = 0;
  bit prev_done = 1'b0;
  int done_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance, then sample #1 after the edge and run the per-cycle monitor.
  task automatic tick();
    int exp_t;
    @(posedge clock);
    #1;
    cyc++;
    check("load_iter_overlap", 32'(bus.load & bus.iter_en), 0);
    if (prev_done) check("ready_after_done", 32'(bus.ready), 1);
    if (bus.load) exp_iter = 0;
    if (bus.iter_en) begin
      n_iter_en++;
      check("iter_seq", 32'(bus.iter), exp_iter);
      check("last_flag", 32'(bus.last), 32'(exp_iter == N - 1));
      if (bus.iter == '0) check("angle_zero", z, 0);
      exp_iter++;
    end else begin
      check("last_idle", 32'(bus.last), 0);
    end
    if (bus.done) begin
      exp_t = (done_q.size() > 0) ? done_q.pop_front() : -1;
      check("done_cycle", cyc, exp_t);
    end
    prev_done = bus.done;
  endtask

  task automatic issue(input bit expect_done);
    bus.start = 1'b1;
    if (expect_done) done_q.push_back(cyc + N + 2);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !bus.done; i++) tick();
    check(tag, 32'(bus.done), 1);
  endtask

  task automatic wait_iter(input string tag, input int v, input int budget);
    for (int i = 0; i < budget && !(bus.iter_en && int'(bus.iter) == v); i++) tick();
    check(tag, 32'(bus.iter), 32'(v));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},   32'(bus.ready), 1);
    check({tag, "_busy"},    32'(bus.busy), 0);
    check({tag, "_load"},    32'(bus.load), 0);
    check({tag, "_iter_en"}, 32'(bus.iter_en), 0);
    check({tag, "_iter"},    32'(bus.iter), 0);
    check({tag, "_last"},    32'(bus.last), 0);
    check({tag, "_done"},    32'(bus.done), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;  bus.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;

    // Reset held for two cycles
    tick(); tick();
    check_reset_vals("rst");
    check("rst1_ready", 32'(bus1.ready), 1);
    reset = 1'b0;
    tick();

    // Single operation
    n_iter_en = 0;
    issue(1'b1);
    check("op_load", 32'(bus.load), 1);
    check("op_busy", 32'(bus.busy), 1);
    check("op_ready_low", 32'(bus.ready), 0);
    tick();
    check("op_first_iter_en", 32'(bus.iter_en), 1);
    wait_done("op_done", 40);
    check("op_done_busy", 32'(bus.busy), 0);
    check("op_done_ready", 32'(bus.ready), 0);
    check("op_iter_count", n_iter_en, N);
    tick();
    check("op_idle_done_low", 32'(bus.done), 0);

    // start held high for 100 cycles: operations every N+3 cycles
    bus.start = 1'b1;
    done_q.push_back(cyc + N + 2);
    done_q.push_back(cyc + 2 * N + 5);
    done_q.push_back(cyc + 3 * N + 8);
    repeat (100) tick();
    bus.start = 1'b0;
    wait_done("b2b_last_done", 20);
    check("b2b_queue_drained", done_q.size(), 0);
    tick();

    // start during ITER is ignored
    issue(1'b1);
    wait_iter("ign_reach10", 10, 20);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("ign_busy", 32'(bus.busy), 1);
    wait_done("ign_done", 40);
    tick();
    repeat (3) begin
      tick();
      check("ign_no_reload", 32'(bus.load), 0);
    end

    // abort at iter=5, then start+abort together in IDLE
    issue(1'b0);
    wait_iter("abt_reach5", 5, 20);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_reset_vals("abt");
    repeat (3) tick();
    bus.abort = 1'b1;
    issue(1'b1);
    bus.abort = 1'b0;
    check("abt_start_wins", 32'(bus.load), 1);
    wait_done("abt_fresh_done", 40);
    tick();

    // synchronous reset mid-operation
    issue(1'b0);
    wait_iter("rmid_reach20", 20, 30);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("rmid");
    repeat (40) tick();

    // N_ITER=1 corner instance
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("n1_load", 32'(bus1.load), 1);
    tick();
    check("n1_iter_en", 32'(bus1.iter_en), 1);
    check("n1_iter", 32'(bus1.iter), 0);
    check("n1_last", 32'(bus1.last), 1);
    check("n1_load_low", 32'(bus1.load), 0);
    tick();
    check("n1_done", 32'(bus1.done), 1);
    check("n1_ready_low", 32'(bus1.ready), 0);
    tick();
    check("n1_ready", 32'(bus1.ready), 1);
    check("n1_done_low", 32'(bus1.done), 0);

    check("final_queue_empty", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
